// File: rtl/mult_shift_add32.sv
// mult_shift_add32: iterative shift-add 32x32->64 multiplier (MULT/MULTU) with start/busy/done handshake

// full_adder32bit: 32-bit adder/subtractor producing sum and carry out
module full_adder32bit #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             subtract,
   output logic [WIDTH-1:0] sum,
   output logic             carryout
);
   logic [WIDTH-1:0] y_eff;
   assign y_eff = y ^ {WIDTH{subtract}};
   assign {carryout, sum} = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, subtract};
endmodule

module mult_shift_add32 #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   logic [1:0]         state;
   logic [CNT_W-1:0]   count;
   logic [WIDTH-1:0]   mcand, acc_hi, acc_lo;
   logic               neg;
   logic [WIDTH-1:0]   abs_a, abs_b, sum, s;
   logic               carry, c;
   logic [2*WIDTH-1:0] prod, res;

   full_adder32bit #(.WIDTH(WIDTH)) u_add (
      .x(acc_hi), .y(mcand), .subtract(1'b0), .sum(sum), .carryout(carry)
   );

   assign busy = state != IDLE;

   // operand magnitudes, partial-product select and final sign fix-up
   always_comb begin
      abs_a = (signed_op && a[WIDTH-1]) ? -a : a;
      abs_b = (signed_op && b[WIDTH-1]) ? -b : b;
      c     = acc_lo[0] & carry;
      s     = acc_lo[0] ? sum : acc_hi;
      prod  = {acc_hi, acc_lo};
      res   = neg ? -prod : prod;
   end

   // control FSM and shift-add datapath; reset aborts any multiply in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         count  <= '0;
         mcand  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         neg    <= 1'b0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               mcand  <= abs_a;
               acc_lo <= abs_b;
               acc_hi <= '0;
               count  <= '0;
               neg    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
               state  <= RUN;
            end
            RUN: begin
               acc_hi <= {c, s[WIDTH-1:1]};
               acc_lo <= {s[0], acc_lo[WIDTH-1:1]};
               count  <= count + 1'b1;
               state  <= (count == LAST) ? FIX : RUN;
            end
            FIX: begin
               hi    <= res[2*WIDTH-1:WIDTH];
               lo    <= res[WIDTH-1:0];
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mult_shift_add32.sv
// tb_mult_shift_add32: directed and randomised checks of mult_shift_add32 against an arithmetic product model
module tb_mult_shift_add32;
   logic        clk = 0, reset = 1, start = 0, signed_op = 0;
   logic [31:0] a = 0, b = 0;
   logic        busy, done;
   logic [31:0] hi, lo;
   int          checks = 0, errors = 0;
   logic [63:0] prev_hl = 0;
   logic        prev_rst = 1;

   mult_shift_add32 dut (
      .clk(clk), .reset(reset), .start(start), .signed_op(signed_op),
      .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic sg, input logic [31:0] x, input logic [31:0] y);
      logic signed [63:0] sx, sy;
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      return sg ? 64'(sx * sy) : {32'b0, x} * {32'b0, y};
   endfunction

   // hi/lo may only change on the edge that raises done (or a reset edge)
   always @(negedge clk) begin
      if (!done && !prev_rst) chk("hold", {hi, lo}, prev_hl);
      prev_hl  = {hi, lo};
      prev_rst = reset;
   end

   task automatic launch(input logic sg, input logic [31:0] x, input logic [31:0] y);
      signed_op = sg; a = x; b = y; start = 1;
      @(posedge clk); #1;
      start = 0; a = $urandom; b = $urandom; signed_op = 1'($urandom);
   endtask

   task automatic wait_done(output int cyc, output int bc);
      cyc = 0; bc = 0;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (busy) bc++;
         chk("busy_done_excl", {63'b0, busy & done}, 64'd0);
      end
      chk("done_seen", {63'b0, done}, 64'd1);
   endtask

   task automatic mul(input string tag, input logic sg, input logic [31:0] x, input logic [31:0] y);
      int cyc, bc;
      @(posedge clk); #1;
      launch(sg, x, y);
      wait_done(cyc, bc);
      chk(tag, {hi, lo}, model(sg, x, y));
   endtask

   initial begin
      int cyc, bc;
      logic [31:0] rx, ry;
      logic rs;
      repeat (2) @(posedge clk);
      #1 reset = 0;
      @(negedge clk);
      chk("reset_state", {busy, done, hi, lo}, 66'd0);

      @(posedge clk); #1;
      launch(0, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done(cyc, bc);
      chk("t1_result", {hi, lo}, 64'hFFFFFFFE_00000001);
      chk("t1_latency", 64'(cyc), 64'd34);
      chk("t1_busy_cycles", 64'(bc), 64'd33);

      mul("t2_mult_neg1", 1, 32'hFFFFFFFF, 32'h1);
      chk("t2_mult_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFF);
      mul("t2_multu", 0, 32'hFFFFFFFF, 32'h1);
      chk("t2_multu_const", {hi, lo}, 64'h00000000_FFFFFFFF);
      mul("t3_min_min", 1, 32'h80000000, 32'h80000000);
      chk("t3_min_min_const", {hi, lo}, 64'h40000000_00000000);
      mul("t3_min_one", 1, 32'h80000000, 32'h1);
      chk("t3_min_one_const", {hi, lo}, 64'hFFFFFFFF_80000000);

      @(posedge clk); #1;
      launch(0, 32'hAAAAAAAA, 32'h2);
      repeat (9) @(posedge clk);
      #1 start = 1; a = 5; b = 5; signed_op = 0;
      @(posedge clk); #1 start = 0;
      wait_done(cyc, bc);
      chk("t4_ignore_start", {hi, lo}, 64'h00000001_55555554);
      launch(0, 32'd3, 32'd7);
      @(negedge clk);
      chk("t4_b2b_busy", {63'b0, busy}, 64'd1);
      chk("t4_b2b_done_drop", {63'b0, done}, 64'd0);
      chk("t4_old_result_kept", {hi, lo}, 64'h00000001_55555554);
      wait_done(cyc, bc);
      chk("t4_b2b_result", {hi, lo}, 64'd21);

      @(posedge clk); #1;
      launch(0, 32'h12345678, 32'h9ABCDEF0);
      repeat (9) @(posedge clk);
      #1 reset = 1;
      @(posedge clk); #1 reset = 0;
      @(negedge clk);
      chk("t5_abort_state", {busy, done, hi, lo}, 66'd0);
      cyc = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) cyc++;
      end
      chk("t5_no_done", 64'(cyc), 64'd0);
      mul("t5_fresh", 0, 32'd2, 32'd3);
      chk("t5_fresh_const", {hi, lo}, 64'd6);

      for (int i = 0; i < 200; i++) begin
         rs = 1'($urandom);
         rx = $urandom;
         ry = $urandom;
         if (i % 20 == 0) rx = 32'h80000000;
         if (i % 30 == 0) ry = 32'h0;
         mul("rand", rs, rx, ry);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
